// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  function automatic logic [INST_W-1:0] align_word(input logic [INST_W-1:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface if_stage_if;
  import if_pkg::*;

  logic              req;
  logic [INST_W-1:0] addr;
  logic              ready;
  logic [INST_W-1:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/if_skid_buf.sv
// One-entry {pc, inst} holding buffer for a response that arrives while IF/ID stalls.
module if_skid_buf
  import if_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              unload,
  input  logic              clear,
  input  logic [INST_W-1:0] pc_in,
  input  logic [INST_W-1:0] inst_in,
  output logic [INST_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              valid_o
);

  logic [INST_W-1:0] pc_d, pc_q, inst_d, inst_q;
  logic              valid_d, valid_q;

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (clear) begin
      pc_d    = 32'h0000_0000;
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (load) begin
      pc_d    = pc_in;
      inst_d  = inst_in;
      valid_d = 1'b1;
    end else if (unload) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= 32'h0000_0000;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding imem request, skid buffer for stalls,
// and wrong-path discard on redirect.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_in,
  input  logic              redirect,
  input  logic [INST_W-1:0] redirect_pc,
  if_stage_if.master        imem,
  output logic [INST_W-1:0] pc_out,
  output logic [INST_W-1:0] inst_out,
  output logic              inst_valid
);

  fetch_state_e      state_d, state_q;
  logic [INST_W-1:0] pc_d, pc_q, addr_d, addr_q;
  logic [INST_W-1:0] pc_out_d, pc_out_q, inst_d, inst_q;
  logic              req_d, req_q, drop_d, drop_q, valid_d, valid_q;
  logic              skid_load, skid_unload, skid_clear, skid_valid;
  logic [INST_W-1:0] skid_pc, skid_inst, target, next_addr;

  if_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .unload  (skid_unload),
    .clear   (skid_clear),
    .pc_in   (addr_q),
    .inst_in (imem.rdata),
    .pc_o    (skid_pc),
    .inst_o  (skid_inst),
    .valid_o (skid_valid)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    req_d       = req_q;
    drop_d      = drop_q;
    pc_out_d    = pc_out_q;
    inst_d      = inst_q;
    valid_d     = valid_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;
    target      = align_word(redirect_pc);
    next_addr   = addr_q + 32'd4;

    // Redirect bubbles the output even under stall; the wrong-path entry must not survive.
    if (redirect) begin
      pc_d       = target;
      pc_out_d   = 32'h0000_0000;
      inst_d     = NOP_INST;
      valid_d    = 1'b0;
      skid_clear = 1'b1;
    end else begin
      pc_d = pc_q;
    end

    case (state_q)
      IDLE: begin
        state_d = BUSY;
        req_d   = 1'b1;
        addr_d  = redirect ? target : pc_q;
      end
      BUSY: begin
        if (req_q && imem.ready) begin
          if (drop_q || redirect) begin
            // Wrong-path response: discard it and re-issue at the current pc.
            drop_d = 1'b0;
            addr_d = redirect ? target : pc_q;
            if (!redirect && !stall_in) begin
              pc_out_d = 32'h0000_0000;
              inst_d   = NOP_INST;
              valid_d  = 1'b0;
            end else begin
              valid_d = valid_d;
            end
          end else if (!stall_in) begin
            pc_out_d = addr_q;
            inst_d   = imem.rdata;
            valid_d  = 1'b1;
            pc_d     = next_addr;
            addr_d   = next_addr;
          end else begin
            skid_load = 1'b1;
            pc_d      = next_addr;
            req_d     = 1'b0;
            state_d   = HOLD;
          end
        end else if (redirect) begin
          // Request must stay stable on the bus, so remember to drop its response.
          drop_d = 1'b1;
        end else if (!stall_in) begin
          pc_out_d = 32'h0000_0000;
          inst_d   = NOP_INST;
          valid_d  = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_d = BUSY;
          req_d   = 1'b1;
          addr_d  = target;
        end else if (!stall_in) begin
          pc_out_d    = skid_pc;
          inst_d      = skid_inst;
          valid_d     = skid_valid;
          skid_unload = 1'b1;
          state_d     = BUSY;
          req_d       = 1'b1;
          addr_d      = pc_q;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        drop_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      req_q    <= 1'b0;
      drop_q   <= 1'b0;
      pc_out_q <= 32'h0000_0000;
      inst_q   <= NOP_INST;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      drop_q   <= drop_d;
      pc_out_q <= pc_out_d;
      inst_q   <= inst_d;
      valid_q  <= valid_d;
    end
  end

  assign imem.req   = req_q;
  assign imem.addr  = addr_q;
  assign pc_out     = pc_out_q;
  assign inst_out   = inst_q;
  assign inst_valid = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed table-driven bench for if_stage with a variable-latency memory model.
module tb_if_stage;
  import if_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in, redirect;
  logic [31:0] redirect_pc, pc_out, inst_out;
  logic        inst_valid;
  int          lat;
  int          cnt;
  int          errors = 0;
  int          checks = 0;

  if_stage_if bus ();

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_in    (stall_in),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus.master),
    .pc_out      (pc_out),
    .inst_out    (inst_out),
    .inst_valid  (inst_valid)
  );

  always #5 clk = ~clk;

  // Memory answers after `lat` wait cycles of a held request.
  always @(posedge clk) begin
    if (!rst || !bus.req || bus.ready) cnt <= 0;
    else cnt <= cnt + 1;
  end
  assign bus.ready = bus.req && (cnt >= lat);
  assign bus.rdata = bus.addr ^ KEY;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    int          lat;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_req;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic r, logic [31:0] rp, int l,
                              logic ev, logic [31:0] ep, logic er, logic [31:0] ea);
    vec_t v;
    v.stall = s; v.redir = r; v.rpc = rp; v.lat = l;
    v.e_valid = ev; v.e_pc = ep; v.e_inst = ev ? (ep ^ KEY) : 32'h0;
    v.e_req = er; v.e_addr = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [31:0] ep,
                         input logic [31:0] ei, input logic er, input logic [31:0] ea);
    chk({tag, " inst_valid"}, {31'd0, inst_valid}, {31'd0, ev});
    chk({tag, " pc_out"}, pc_out, ep);
    chk({tag, " inst_out"}, inst_out, ei);
    chk({tag, " imem_req"}, {31'd0, bus.req}, {31'd0, er});
    if (er) chk({tag, " imem_addr"}, bus.addr, ea);
  endtask

  initial begin
    rst = 1'b0; stall_in = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; lat = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("reset addr", bus.addr, 32'h0);

    //          stall redir rpc           lat valid pc            req  addr
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,          1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h0,          1, 32'h4));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h4,          1, 32'h8));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h8,          1, 32'hC));
    vecs.push_back(mk(0, 0, 32'h0,        3, 0, 32'h0,          1, 32'hC));
    vecs.push_back(mk(0, 0, 32'h0,        3, 0, 32'h0,          1, 32'hC));
    vecs.push_back(mk(0, 0, 32'h0,        3, 0, 32'h0,          1, 32'hC));
    vecs.push_back(mk(0, 0, 32'h0,        3, 1, 32'hC,          1, 32'h10));
    vecs.push_back(mk(1, 0, 32'h0,        3, 1, 32'hC,          1, 32'h10));
    vecs.push_back(mk(1, 0, 32'h0,        3, 1, 32'hC,          1, 32'h10));
    vecs.push_back(mk(1, 0, 32'h0,        3, 1, 32'hC,          1, 32'h10));
    vecs.push_back(mk(1, 0, 32'h0,        3, 1, 32'hC,          0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h10,         1, 32'h14));
    vecs.push_back(mk(0, 0, 32'h0,        2, 0, 32'h0,          1, 32'h14));
    vecs.push_back(mk(0, 1, 32'h203,      2, 0, 32'h0,          1, 32'h14));
    vecs.push_back(mk(0, 0, 32'h0,        2, 0, 32'h0,          1, 32'h200));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h200,        1, 32'h204));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1, 32'h200,        0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1, 32'h200,        0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h300,      0, 0, 32'h0,          1, 32'h300));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h300,        1, 32'h304));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h304,        1, 32'h308));
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFE, 0, 0, 32'h0,         1, 32'hFFFF_FFFC));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hFFFF_FFFC,  1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h0,          1, 32'h4));

    rst = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      stall_in    = vecs[i].stall;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      lat         = vecs[i].lat;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc,
              vecs[i].e_inst, vecs[i].e_req, vecs[i].e_addr);
    end

    // Reset asserted while a slow request is outstanding.
    stall_in = 1'b0; redirect = 1'b0; lat = 5;
    @(posedge clk);
    #1;
    chk_all("slow req", 1'b0, 32'h0, 32'h0, 1'b1, 32'h4);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_all("mid reset", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("mid reset addr", bus.addr, 32'h0);
    rst = 1'b1; lat = 0;
    @(posedge clk);
    #1;
    chk_all("restart", 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    @(posedge clk);
    #1;
    chk_all("restart fetch", 1'b1, 32'h0, KEY, 1'b1, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage pipeline. Holds the program counter, issues one outstanding request at a time to instruction memory over a req/ready handshake, and presents the fetched instruction and its address to the IF/ID pipeline register. It tolerates variable memory latency, absorbs downstream stalls in a one-entry skid buffer, and discards wrong-path fetches on a branch or jump redirect.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset.
- stall_in  in  1  IF/ID is holding; outputs must not change.
- redirect  in  1  taken branch/jump from a later stage; flushes the fetch path.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced to 00).
- imem_req  out  1  request valid; once raised, held with imem_addr stable until imem_ready is sampled high.
- imem_addr  out  32  word-aligned fetch address.
- imem_ready  in  1  response valid this cycle; only meaningful while imem_req=1.
- imem_rdata  in  32  instruction word; valid when imem_req & imem_ready.
- pc_out  out  32  address of inst_out; feeds IF/ID pc_in.
- inst_out  out  32  fetched instruction, or NOP 32'h0 when invalid; feeds IF/ID inst_in.
- inst_valid  out  1  inst_out holds a real instruction.

## Operation
- Reset (rst=0 at edge): pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, pc_out=0, inst_out=0, inst_valid=0, skid empty, drop=0. Any outstanding request is abandoned.
- States:
  - IDLE: next edge -> BUSY.
  - BUSY: imem_req=1, imem_addr=pc.
  - HOLD: response captured in skid; imem_req=0.
- BUSY, accepted response (imem_ready=1, drop=0, no redirect):
  - stall_in=0: output <= {imem_addr, imem_rdata, valid=1}; pc <= imem_addr+4; stay BUSY.
  - stall_in=1: skid <= {imem_addr, imem_rdata}; pc <= imem_addr+4; -> HOLD.
- BUSY, imem_ready=0: if stall_in=0, output <= bubble {0, 0, valid=0}; otherwise hold.
- HOLD, stall_in=0: output <= skid with valid=1; -> BUSY requesting pc.
- Redirect (priority over stall_in and all normal updates):
  - pc <= {redirect_pc[31:2], 2'b00}; output <= bubble; skid cleared.
  - BUSY with imem_ready=0: set drop; request stays stable.
  - BUSY with imem_ready=1: response discarded; next request uses the new pc.
  - HOLD: -> BUSY.
- drop=1 and imem_ready=1: response discarded, drop cleared, next request to pc. A further redirect while drop=1 only updates pc.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). No misalignment trap.

## Timing
- Zero-wait memory (imem_ready=1 every cycle): first request in the cycle after reset release. The instruction at address A appears on inst_out one edge after A is requested. Throughput is 1 instruction per cycle.
- N wait cycles insert N bubbles (inst_valid=0) while stall_in=0.
- stall_in=1 freezes pc_out, inst_out and inst_valid exactly. At most one response is buffered; no request is issued while in HOLD.
- On redirect asserted in cycle t, inst_valid=0 after edge t. The first redirect-target request is raised at edge t, or after the pending response is dropped.
- All outputs are registered. There is no combinational path from stall_in or redirect to imem_req or imem_addr within the same cycle.

## Structure
- Shared package (if_pkg): state enum {IDLE, BUSY, HOLD}, NOP_INST=32'h0, INST_W=32.
- One natural sub-module, if_skid_buf: a one-entry {pc, inst} buffer with load, unload and clear controls. All other logic is inline.

## Test plan
- Reset, then zero-wait memory returning imem_rdata=addr^32'hA5A5_A5A5 -> inst_out sequence for pc_out 0,4,8,… with inst_valid=1 from the second edge after reset release.
- 3-cycle memory latency -> 3 bubbles (inst_out=0, inst_valid=0) between instructions; imem_addr stable throughout each request.
- stall_in=1 for 4 cycles arriving mid-request -> outputs frozen, response for 0x10 lands in skid, imem_req=0; on release, 0x10 is presented next with no loss or duplication.
- redirect to 0x200 while the request for 0x14 waits 2 cycles -> the 0x14 response is dropped and the next valid pc_out is 0x200; redirect_pc=0x203 -> imem_addr=0x200.
- Redirect together with stall_in=1 and a full skid -> bubble output, skid cleared, fetch resumes at the target.
- rst=0 mid-request -> imem_req=0 and all outputs at reset values after one edge; pc=0xFFFF_FFFC wraps to next fetch 0.
